// File: rtl/sensor_pkg.sv
// Shared constants and the controller state type for the sensor aggregator.
// The parameter defaults and the dividend width SW are kept in one place here.
package sensor_pkg;
  localparam int NSAMP_DEF = 4;
  localparam int DW_DEF    = 8;
  localparam int SW_DEF    = DW_DEF + $clog2(NSAMP_DEF);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DIV     = 2'd1,
    OUT     = 2'd2
  } state_e;
endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider that produces one quotient bit per clock.
// start loads the operands; done pulses for one cycle after SW iterations.
module seq_udiv #(
  parameter int SW = 10,
  parameter int VW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [SW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [SW-1:0] quotient
);
  localparam int CW = $clog2(SW + 1);

  logic [VW-1:0] rem_q, rem_d;
  logic [SW-1:0] quo_q, quo_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [VW:0]   shifted;
  logic [VW+1:0] diff;

  always_comb begin
    shifted = {rem_q, quo_q[SW-1]};
    // The top bit of diff is the borrow: set when the trial subtraction fails.
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d = {quo_q[SW-2:0], ~diff[VW+1]};
      rem_d = diff[VW+1] ? shifted[VW-1:0] : diff[VW-1:0];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(SW - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;
endmodule

// File: rtl/sensor_aggregator.sv
// Collects NSAMP distance samples, averages the non-zero ones and hands the mean
// downstream; a frame of only zero samples is reported as a sensor error.
module sensor_aggregator
  import sensor_pkg::*;
#(
  parameter int NSAMP = NSAMP_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_err,
  input  logic          m_ready
);
  localparam int LW = $clog2(NSAMP);
  localparam int SW = DW + LW;
  localparam int CW = LW + 1;

  state_e        state_q, state_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [CW-1:0] nz_q, nz_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_err_q, m_err_d;

  logic          accept, last, nonzero, handoff;
  logic          div_start, div_done;
  logic [SW-1:0] sum_inc, div_quo;
  logic [CW-1:0] nz_inc;
  logic          quo_hi_unused;

  assign nonzero = (s_data != '0);
  assign sum_inc = sum_q + (nonzero ? {{LW{1'b0}}, s_data} : '0);
  assign nz_inc  = nz_q + {{LW{1'b0}}, nonzero};
  assign last    = (cnt_q == CW'(NSAMP - 1));
  // The mean never exceeds the largest sample, so the high quotient bits stay 0.
  assign quo_hi_unused = |div_quo[SW-1:DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (s_valid && last) state_d = (nz_inc != '0) ? DIV : OUT;
      DIV:     if (div_done) state_d = OUT;
      OUT:     if (m_valid_q && m_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    s_ready   = (state_q == COLLECT);
    accept    = (state_q == COLLECT) && s_valid;
    div_start = accept && last && (nz_inc != '0);
    handoff   = (state_q == OUT) && m_valid_q && m_ready;
  end

  always_comb begin
    sum_d     = sum_q;
    nz_d      = nz_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_err_d   = m_err_q;
    if (accept) begin
      cnt_d = cnt_q + 1'b1;
      sum_d = sum_inc;
      nz_d  = nz_inc;
      if (last && (nz_inc == '0)) begin
        m_data_d = '0;
        m_err_d  = 1'b1;
      end
    end
    // All-zero frame: flags settle on entry to OUT, valid follows one edge later.
    if ((state_q == OUT) && !m_valid_q) m_valid_d = 1'b1;
    if ((state_q == DIV) && div_done) begin
      m_valid_d = 1'b1;
      m_err_d   = 1'b0;
      m_data_d  = div_quo[DW-1:0];
    end
    if (handoff) begin
      sum_d     = '0;
      nz_d      = '0;
      cnt_d     = '0;
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      nz_q      <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_err_q   <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      nz_q      <= nz_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_err_q   <= m_err_d;
    end
  end

  seq_udiv #(
    .SW(SW),
    .VW(CW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_inc),
    .divisor  (nz_inc),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_err   = m_err_q;
endmodule

// File: tb/tb_sensor_aggregator.sv
// Randomised and directed frames checked against a plain-arithmetic mean model,
// including latency, output hold under backpressure and mid-frame resets.
module tb_sensor_aggregator;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_err;
  logic       m_ready;

  int total = 0;
  int bad   = 0;

  sensor_aggregator #(.NSAMP(4), .DW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_err   (m_err),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_samples(input logic [7:0] smp[4], input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = smp[i];
      tick();
      s_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_rst_data"},  32'(m_data),  32'd0);
    chk({tag, "_rst_err"},   32'(m_err),   32'd0);
    chk({tag, "_rst_ready"}, 32'(s_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    $display("reset %s", tag);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] smp[4], input int hold,
                           input bit rnd_gaps);
    int sum = 0, nz = 0, n = 0;
    int exp_data, exp_err, exp_lat;
    for (int i = 0; i < 4; i++) begin
      if (smp[i] != 8'd0) begin
        sum += int'(smp[i]);
        nz++;
      end
    end
    exp_data = (nz != 0) ? sum / nz : 0;
    exp_err  = (nz == 0) ? 1 : 0;
    exp_lat  = (nz != 0) ? 11 : 1;

    for (int i = 0; i < 4; i++) begin
      if (rnd_gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          m_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      m_ready = 1'b0;
      chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_data  = smp[i];
      tick();
      s_valid = 1'b0;
    end
    chk({tag, "_busy_ready"}, 32'(s_ready), 32'd0);

    while (m_valid !== 1'b1 && n < 40) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_data"},    32'(m_data), 32'(exp_data));
    chk({tag, "_err"},     32'(m_err),  32'(exp_err));

    for (int h = 0; h < hold; h++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      tick();
      chk({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_hold_data"},  32'(m_data),  32'(exp_data));
      chk({tag, "_hold_err"},   32'(m_err),   32'(exp_err));
      chk({tag, "_hold_ready"}, 32'(s_ready), 32'd0);
    end

    // A sample presented on the handoff edge must not leak into the next frame.
    s_valid = 1'b1;
    s_data  = 8'd77;
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(s_ready), 32'd1);
    $display("frame %s: %0d %0d %0d %0d -> data=%0d err=%0d lat=%0d", tag,
             smp[0], smp[1], smp[2], smp[3], m_data, exp_err, n);
  endtask

  initial begin
    logic [7:0] f[4];
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'd0;
    m_ready = 1'b0;
    #1;
    chk("reset_valid", 32'(m_valid), 32'd0);
    chk("reset_data",  32'(m_data),  32'd0);
    chk("reset_err",   32'(m_err),   32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_ready", 32'(s_ready), 32'd1);

    f = '{8'd16, 8'd36, 8'd64, 8'd100};  run_frame("mean54", f, 5, 1'b0);
    f = '{8'd10, 8'd0, 8'd11, 8'd12};    run_frame("mean11", f, 1, 1'b0);
    f = '{8'd0, 8'd0, 8'd9, 8'd0};       run_frame("single9", f, 2, 1'b1);
    f = '{8'd0, 8'd0, 8'd0, 8'd0};       run_frame("allzero", f, 3, 1'b0);
    f = '{8'd255, 8'd255, 8'd255, 8'd255}; run_frame("max255", f, 1, 1'b0);
    f = '{8'd1, 8'd2, 8'd2, 8'd0};       run_frame("floor", f, 0, 1'b1);

    f = '{8'd200, 8'd200, 8'd200, 8'd200};
    push_samples(f, 4);
    repeat (4) tick();
    do_reset("mid_div");
    f = '{8'd4, 8'd4, 8'd4, 8'd4};       run_frame("after_div_rst", f, 1, 1'b0);

    f = '{8'd0, 8'd0, 8'd0, 8'd0};
    push_samples(f, 4);
    repeat (3) tick();
    do_reset("mid_out");
    f = '{8'd30, 8'd0, 8'd50, 8'd0};     run_frame("after_out_rst", f, 1, 1'b0);

    f = '{8'd250, 8'd250, 8'd0, 8'd0};
    push_samples(f, 2);
    do_reset("partial");
    f = '{8'd8, 8'd0, 8'd0, 8'd6};       run_frame("after_part_rst", f, 1, 1'b1);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ((k % 9) == 5 || $urandom_range(0, 99) < 30) f[i] = 8'd0;
        else f[i] = 8'($urandom_range(1, 255));
      end
      run_frame($sformatf("rnd%0d", k), f, $urandom_range(0, 3), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sensor_aggregator.md
SENSOR_AGGREGATOR -- requirements
Module: sensor_aggregator

Interface
REQ-001 SHALL have parameter NSAMP, default 4, meaning samples per measurement frame (power of two, 2..16).
REQ-002 SHALL have parameter DW, default 8, meaning sample and result width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port s_valid, input, 1, meaning a sample is present on s_data.
REQ-006 SHALL have port s_data, input, DW, meaning raw distance sample; 0 marks a faulty sensor.
REQ-007 SHALL have port s_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-008 SHALL have port m_valid, output, 1, meaning m_data and m_err hold a frame result.
REQ-009 SHALL have port m_data, output, DW, meaning frame mean of non-zero samples; feeds the 8-bit input of the downstream square-root stage.
REQ-010 SHALL have port m_err, output, 1, meaning every sample in the frame was 0.
REQ-011 SHALL have port m_ready, input, 1, meaning the downstream stage consumes the result.

Function
REQ-012 SHALL implement an FSM with states COLLECT, DIV and OUT; the reset state is COLLECT.
REQ-013 COLLECT: s_ready=1; a sample is accepted on an edge where s_valid=1; each accepted non-zero sample is added to sum (width DW+log2(NSAMP), 10 bits at default) and increments nz_cnt; an accepted zero only increments the frame sample counter.
REQ-014 On the edge that accepts sample NSAMP, the FSM SHALL go to DIV if nz_cnt (including this sample) is >0, else to OUT with m_data=0 and m_err=1.
REQ-015 DIV SHALL run a restoring division sum/nz_cnt, one quotient bit per cycle, for exactly SW=DW+log2(NSAMP) cycles; the result is the truncated quotient (floor).
REQ-016 The quotient SHALL always fit in DW bits; its upper SW-DW bits are discarded and are zero by construction.
REQ-017 m_valid SHALL rise SW+1 edges after the edge accepting sample NSAMP (11 at default), or 1 edge after it in the all-zero case.
REQ-018 OUT: m_valid=1; m_data and m_err are stable until the edge where m_ready=1; that edge returns the FSM to COLLECT and clears sum, nz_cnt, the sample counter and m_valid.
REQ-019 s_ready SHALL be 0 in DIV and OUT; a sample cannot be accepted in the same edge as a result handoff.
REQ-020 m_err SHALL be 0 for any frame with at least one non-zero sample.
REQ-021 An m_ready pulse outside OUT SHALL be ignored.

Reset
REQ-022 While rst_n=0 all registers SHALL clear asynchronously: state=COLLECT, s_ready=1 once released, m_valid=0, m_data=0, m_err=0, sum=0, counters=0.
REQ-023 Reset asserted in any state, including mid-DIV or mid-OUT, SHALL discard the partial frame; the next frame starts with a fresh count.
REQ-024 Reset release SHALL be synchronised externally; the block needs no release synchroniser.

Structure
REQ-025 Constants SHALL live in package sensor_pkg: NSAMP and DW defaults, derived SW, and the state enum (COLLECT, DIV, OUT).
REQ-026 The divider SHALL be sub-module seq_udiv (start, dividend SW bits, divisor log2(NSAMP)+1 bits, done, quotient) instantiated once; the FSM waits for done.

Verification
REQ-027 Samples 16,36,64,100 -> m_data=54, m_err=0, m_valid 11 edges after the 4th accept.
REQ-028 Samples 10,0,11,12 -> m_data=11 (33/3), m_err=0; samples 0,0,9,0 -> m_data=9.
REQ-029 Samples 0,0,0,0 -> m_data=0, m_err=1, m_valid one edge after the 4th accept, no DIV cycles.
REQ-030 Samples 255,255,255,255 -> m_data=255, with no overflow of the 10-bit sum (1020).
REQ-031 m_ready held low 5 cycles in OUT -> m_data, m_err and m_valid stable; s_ready=0 throughout; s_valid pulses ignored; the handoff edge returns to COLLECT.
REQ-032 rst_n pulsed low mid-DIV, then samples 4,4,4,4 -> outputs zero during reset; the next result is m_data=4 with no residue from the aborted frame.
